// File: rtl/i2c_txn_sequencer.sv
// Transaction sequencer in front of an I2C byte master: expands one request into
// START / address / write bytes / RESTART / address / read bytes / STOP commands.
module i2c_txn_sequencer #(
  parameter int LEN_W     = 4,
  parameter int TO_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic [LEN_W-1:0] req_wr_len,
  input  logic [LEN_W-1:0] req_rd_len,
  input  logic             wd_valid,
  input  logic [7:0]       wd_data,
  output logic             wd_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err_nack,
  output logic             err_timeout,
  output logic             busy,
  output logic             m_wr_i2c,
  output logic [2:0]       m_cmd,
  output logic [7:0]       m_data_in,
  input  logic             m_ready,
  input  logic             m_done_tick,
  input  logic             m_ack,
  input  logic [7:0]       m_data_out,
  output logic [4:0]       dbg_state
);

  localparam int TO_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACCEPT, S_COMPLETE} state_t;
  typedef enum logic [2:0] {P_START, P_ADDR_W, P_WR, P_RESTART, P_ADDR_R, P_RD, P_STOP} step_t;

  state_t           state_q;
  step_t            step_q, step_d;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] wr_cnt_q, rd_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             nack_q;

  logic             req_ready_q, busy_q, wd_ready_q, rd_valid_q, done_q;
  logic             err_nack_q, err_timeout_q, m_wr_i2c_q;
  logic [7:0]       rd_data_q, m_data_in_q;
  logic [2:0]       m_cmd_q;

  logic             is_byte_step, is_wr_step, issue_go, wait_met, nack_now;
  logic [2:0]       issue_cmd;
  logic [7:0]       issue_data;

  // Handshakes: a request transfers on the cycle req_valid && req_ready are both high;
  // a write byte transfers when the sequencer samples wd_valid high in the write-issue
  // state, and wd_ready is the registered acknowledgement that appears the next cycle.
  always_comb begin
    is_byte_step = (step_q == P_ADDR_W) || (step_q == P_WR) ||
                   (step_q == P_ADDR_R) || (step_q == P_RD);
    is_wr_step   = (step_q == P_ADDR_W) || (step_q == P_WR) || (step_q == P_ADDR_R);
    issue_go     = (state_q == S_ISSUE) && m_ready && ((step_q != P_WR) || wd_valid);
    wait_met     = (state_q == S_ACCEPT) ? !m_ready : (is_byte_step ? m_done_tick : m_ready);
    nack_now     = is_wr_step && m_ack;

    issue_cmd  = CMD_START;
    issue_data = 8'h00;
    case (step_q)
      P_START:   issue_cmd = CMD_START;
      P_ADDR_W:  begin issue_cmd = CMD_WR; issue_data = {addr_q, 1'b0}; end
      P_WR:      begin issue_cmd = CMD_WR; issue_data = wd_data; end
      P_RESTART: issue_cmd = CMD_RESTART;
      P_ADDR_R:  begin issue_cmd = CMD_WR; issue_data = {addr_q, 1'b1}; end
      P_RD:      begin issue_cmd = CMD_RD; issue_data = {7'b0, rd_cnt_q == LEN_W'(1)}; end
      P_STOP:    issue_cmd = CMD_STOP;
      default:   issue_cmd = CMD_STOP;
    endcase

    // Any NACK on a write-direction byte aborts straight to STOP.
    step_d = P_STOP;
    case (step_q)
      P_START:   step_d = ((wr_cnt_q != '0) || (rd_cnt_q == '0)) ? P_ADDR_W : P_ADDR_R;
      P_ADDR_W:  step_d = (!nack_now && (wr_cnt_q != '0)) ? P_WR : P_STOP;
      P_WR: begin
        if (!nack_now) begin
          if (wr_cnt_q > LEN_W'(1))  step_d = P_WR;
          else if (rd_cnt_q != '0)   step_d = P_RESTART;
          else                       step_d = P_STOP;
        end
      end
      P_RESTART: step_d = P_ADDR_R;
      P_ADDR_R:  step_d = (!nack_now && (rd_cnt_q != '0)) ? P_RD : P_STOP;
      P_RD:      step_d = (rd_cnt_q > LEN_W'(1)) ? P_RD : P_STOP;
      default:   step_d = P_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      step_q        <= P_START;
      addr_q        <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      to_cnt_q      <= '0;
      nack_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      wd_ready_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      done_q        <= 1'b0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      m_wr_i2c_q    <= 1'b0;
      m_cmd_q       <= '0;
      m_data_in_q   <= '0;
    end else begin
      m_wr_i2c_q    <= 1'b0;
      wd_ready_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wr_cnt_q    <= req_wr_len;
            rd_cnt_q    <= req_rd_len;
            nack_q      <= 1'b0;
            step_q      <= P_START;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_go) begin
            m_wr_i2c_q  <= 1'b1;
            m_cmd_q     <= issue_cmd;
            m_data_in_q <= issue_data;
            wd_ready_q  <= (step_q == P_WR);
            to_cnt_q    <= '0;
            state_q     <= S_ACCEPT;
          end
        end
        S_ACCEPT, S_COMPLETE: begin
          if (wait_met) begin
            to_cnt_q <= '0;
            if (state_q == S_ACCEPT) begin
              state_q <= S_COMPLETE;
            end else begin
              if (step_q == P_WR) wr_cnt_q <= wr_cnt_q - LEN_W'(1);
              if (step_q == P_RD) begin
                rd_cnt_q   <= rd_cnt_q - LEN_W'(1);
                rd_data_q  <= m_data_out;
                rd_valid_q <= 1'b1;
              end
              if (nack_now) nack_q <= 1'b1;
              if (step_q == P_STOP) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                err_nack_q <= nack_q;
              end else begin
                step_q  <= step_d;
                state_q <= S_ISSUE;
              end
            end
          end else if (to_cnt_q == TO_LAST) begin
            // Master hung: abandon the bus without a STOP.
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            err_timeout_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign wd_ready    = wd_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;
  assign err_nack    = err_nack_q;
  assign err_timeout = err_timeout_q;
  assign m_wr_i2c    = m_wr_i2c_q;
  assign m_cmd       = m_cmd_q;
  assign m_data_in   = m_data_in_q;
  assign dbg_state   = {step_q, state_q};

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: behavioural I2C master, command-list reference model,
// randomized and directed transactions.
module tb_i2c_txn_sequencer;
  localparam int LEN_W = 4;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [6:0]       req_addr;
  logic [LEN_W-1:0] req_wr_len, req_rd_len;
  logic             wd_valid, wd_ready;
  logic [7:0]       wd_data;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             done, err_nack, err_timeout, busy;
  logic             m_wr_i2c;
  logic [2:0]       m_cmd;
  logic [7:0]       m_data_in;
  logic             m_ready, m_done_tick, m_ack;
  logic [7:0]       m_data_out;
  logic [4:0]       dbg_state;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.LEN_W(LEN_W), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr_len(req_wr_len), .req_rd_len(req_rd_len),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err_nack(err_nack), .err_timeout(err_timeout), .busy(busy),
    .m_wr_i2c(m_wr_i2c), .m_cmd(m_cmd), .m_data_in(m_data_in),
    .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_data_out(m_data_out),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [10:0] exp_cmd_q[$];
  logic [7:0]  exp_wd_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  wd_src_q[$];
  logic [7:0]  bfm_rd_q[$];
  logic [7:0]  wd_b[16];
  logic [7:0]  rd_b[16];
  logic        exp_nack, exp_to;
  int          bfm_nack_idx = -1;
  int          bfm_wr_idx   = 0;
  bit          bfm_hang     = 0;
  bit          wd_gate      = 1;
  int          done_cnt     = 0;
  int          strobe_cyc   = 0;
  int          done_cyc     = 0;
  bit          prev_done    = 0;
  logic [2:0]  bfm_cmd;
  int          bfm_lat;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural master: drops ready after a strobe, completes after a random latency.
  initial begin
    m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (m_wr_i2c === 1'b1 && !bfm_hang) begin
        bfm_cmd = m_cmd;
        bfm_lat = $urandom_range(1, 5);
        @(posedge clk); #1 m_ready = 1'b0;
        repeat (bfm_lat) @(posedge clk);
        #1;
        if (bfm_cmd == 3'd1 || bfm_cmd == 3'd2) begin
          m_done_tick = 1'b1;
          if (bfm_cmd == 3'd1) begin
            m_ack = (bfm_wr_idx == bfm_nack_idx);
            bfm_wr_idx++;
            m_data_out = 8'($urandom);
          end else begin
            m_ack = 1'b0;
            m_data_out = (bfm_rd_q.size() > 0) ? bfm_rd_q.pop_front() : 8'h00;
          end
          if ($urandom_range(0, 1) == 1) m_ready = 1'b1;
          @(posedge clk); #1;
          m_done_tick = 1'b0; m_ack = 1'b0; m_ready = 1'b1;
        end else begin
          m_ready = 1'b1;
        end
      end
    end
  end

  // Write-data source with random gaps.
  initial begin
    wd_valid = 1'b0; wd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (wd_ready === 1'b1 && wd_src_q.size() > 0) void'(wd_src_q.pop_front());
      if (wd_gate && wd_src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        wd_valid = 1'b1; wd_data = wd_src_q[0];
      end else begin
        wd_valid = 1'b0; wd_data = 8'($urandom);
      end
    end
  end

  // Scoreboard.
  always @(negedge clk) begin
    logic [10:0] e11;
    logic [7:0]  e8;
    if (rst === 1'b1) begin
      if (prev_done) begin
        chk("req_ready_after_done", req_ready, 1);
        chk("busy_after_done", busy, 0);
      end
      prev_done = (done === 1'b1);
      if (m_wr_i2c === 1'b1) begin
        strobe_cyc = cyc;
        e11 = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 'x;
        chk("cmd", {m_cmd, m_data_in}, e11);
      end
      if (wd_ready === 1'b1) begin
        e8 = (exp_wd_q.size() > 0) ? exp_wd_q.pop_front() : 'x;
        chk("wd_byte", m_data_in, e8);
        chk("wd_with_wr", {m_wr_i2c, m_cmd}, {1'b1, 3'd1});
      end
      if (rd_valid === 1'b1) begin
        e8 = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 'x;
        chk("rd_data", rd_data, e8);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk("err_nack", err_nack, exp_nack);
        chk("err_timeout", err_timeout, exp_to);
        chk("req_ready_in_done", req_ready, 0);
      end
    end
  end

  // Reference model: the bus command list a request must produce.
  task automatic model(input logic [6:0] a, input int wl, input int rl, input int nk);
    bit ab;
    exp_cmd_q.delete(); exp_wd_q.delete(); exp_rd_q.delete();
    exp_cmd_q.push_back({3'd0, 8'h00});
    if (wl == 0 && rl > 0) begin
      exp_cmd_q.push_back({3'd1, a, 1'b1});
      ab = (nk == 0);
    end else begin
      exp_cmd_q.push_back({3'd1, a, 1'b0});
      ab = (nk == 0);
      for (int i = 0; i < wl && !ab; i++) begin
        exp_cmd_q.push_back({3'd1, wd_b[i]});
        exp_wd_q.push_back(wd_b[i]);
        ab = (nk == i + 1);
      end
      if (!ab && rl > 0) begin
        exp_cmd_q.push_back({3'd4, 8'h00});
        exp_cmd_q.push_back({3'd1, a, 1'b1});
        ab = (nk == wl + 1);
      end
    end
    if (!ab) begin
      for (int j = 0; j < rl; j++) begin
        exp_cmd_q.push_back({3'd2, 7'b0, (j == rl - 1) ? 1'b1 : 1'b0});
        exp_rd_q.push_back(rd_b[j]);
      end
    end
    exp_cmd_q.push_back({3'd3, 8'h00});
    exp_nack = ab;
    exp_to   = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      wd_b[i] = 8'($urandom);
      rd_b[i] = 8'($urandom);
    end
  endtask

  task automatic run_txn(input logic [6:0] a, input int wl, input int rl, input int nk,
                         input bit hang);
    int n0;
    if (hang) begin
      exp_cmd_q.delete(); exp_wd_q.delete(); exp_rd_q.delete();
      exp_cmd_q.push_back({3'd0, 8'h00});
      exp_nack = 1'b0;
      exp_to   = 1'b1;
    end else begin
      model(a, wl, rl, nk);
    end
    wd_src_q.delete(); bfm_rd_q.delete();
    for (int i = 0; i < wl; i++) wd_src_q.push_back(wd_b[i]);
    for (int j = 0; j < rl; j++) bfm_rd_q.push_back(rd_b[j]);
    bfm_nack_idx = nk;
    bfm_wr_idx   = 0;
    bfm_hang     = hang;
    n0 = done_cnt;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_addr = a; req_wr_len = LEN_W'(wl); req_rd_len = LEN_W'(rl); req_valid = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    chk("req_ready_while_busy", req_ready, 0);
    req_addr = ~a; req_wr_len = 4'hF; req_rd_len = 4'hF;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4000 && done_cnt == n0; k++) @(negedge clk);
    chk("done_seen", done_cnt, n0 + 1);
    repeat (2) @(negedge clk);
    chk("cmds_left", exp_cmd_q.size(), 0);
    chk("wd_left", exp_wd_q.size(), 0);
    chk("rd_left", exp_rd_q.size(), 0);
    if (hang) begin
      chk("timeout_latency", ((done_cyc - strobe_cyc) >= TO - 1 &&
                              (done_cyc - strobe_cyc) <= TO + 1) ? 1 : 0, 1);
      bfm_hang = 0;
    end
    wd_src_q.delete(); bfm_rd_q.delete();
    bfm_nack_idx = -1;
  endtask

  initial begin
    int wl, rl, nk, nwr, n0;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wr_len = '0; req_rd_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", m_wr_i2c, 0);
    chk("rst_outs", {done, err_nack, err_timeout, wd_ready, rd_valid}, 0);
    chk("rst_cmd_data", {m_cmd, m_data_in, rd_data}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, slave ACKs.
    fill_random(); wd_b[0] = 8'hAA;
    run_txn(7'h55, 1, 0, -1, 0);
    // Register read: write pointer, repeated start, two reads.
    fill_random(); wd_b[0] = 8'h10; rd_b[0] = 8'hF0; rd_b[1] = 8'h0F;
    run_txn(7'h55, 1, 2, -1, 0);
    // Address NACK with pending write bytes.
    fill_random();
    run_txn(7'h55, 3, 0, 0, 0);
    // Address probe.
    run_txn(7'h55, 0, 0, -1, 0);
    // Master hangs after START.
    fill_random();
    run_txn(7'h2A, 1, 0, -1, 1);

    for (int t = 0; t < 20; t++) begin
      fill_random();
      wl  = $urandom_range(0, 4);
      rl  = $urandom_range(0, 3);
      nwr = (wl == 0 && rl > 0) ? 1 : 1 + wl + ((rl > 0) ? 1 : 0);
      nk  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nwr - 1) : -1;
      run_txn(7'($urandom), wl, rl, nk, 0);
    end

    // Write stall longer than the timeout, then reset mid-transaction.
    fill_random();
    wd_gate = 0;
    model(7'h33, 2, 0, -1);
    exp_cmd_q.delete();
    exp_cmd_q.push_back({3'd0, 8'h00});
    exp_cmd_q.push_back({3'd1, 7'h33, 1'b0});
    wd_src_q.delete();
    wd_src_q.push_back(wd_b[0]); wd_src_q.push_back(wd_b[1]);
    n0 = done_cnt;
    @(negedge clk);
    req_addr = 7'h33; req_wr_len = 4'd2; req_rd_len = 4'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (70) @(negedge clk);
    chk("stall_no_done", done_cnt, n0);
    chk("stall_cmds_issued", exp_cmd_q.size(), 0);
    chk("stall_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_strobe", m_wr_i2c, 0);
    chk("async_rst_req_ready", req_ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_outs", {done, err_nack, err_timeout, wd_ready, rd_valid}, 0);
    @(negedge clk);
    rst = 1'b1;
    wd_gate = 1;
    wd_src_q.delete();
    exp_wd_q.delete();
    repeat (2) @(negedge clk);

    fill_random();
    run_txn(7'h11, 2, 1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
